// File: rtl/memfifo_test_checker.sv
// memfifo_test_checker: reader-side checker for the memfifo test data stream.
// Consumes 16-bit words drained from the DRAM FIFO, aligns to the 16-byte
// generator block and verifies sync bits, the 7-bit counter and the block
// checksum. Lock state and error/throughput counters are exposed for LEDs/debug.
module memfifo_test_checker #(
  parameter int unsigned LOSS_BLOCKS = 4,
  parameter logic [6:0]  CNT_STEP    = 7'd111,
  parameter logic [13:0] CS_INIT     = 14'd47
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic [15:0] DI,
  input  logic        DI_valid,
  output logic        DI_ready,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [31:0] blk_ok_cnt,
  output logic [15:0] blk_err_cnt,
  output logic        lock_lost
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [3:0] LOSS      = 4'(LOSS_BLOCKS);
  localparam logic [6:0] CNT_STEP2 = CNT_STEP + CNT_STEP;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wpos;
  logic [2:0]  wpos_nxt;
  logic [6:0]  exp_cnt;
  logic [6:0]  exp_cnt_nxt;
  logic [13:0] cs;
  logic [13:0] cs_nxt;
  logic [3:0]  bad_run;
  logic [3:0]  bad_run_nxt;
  logic        blk_bad;
  logic        blk_bad_nxt;

  logic        accept;
  logic        word_err;
  logic        blk_end;
  logic        blk_end_bad;
  logic        lose_lock;

  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic [6:0]  seed_hi_exp;
  logic [6:0]  hi_cnt_exp;
  logic [13:0] cs_lo;
  logic [13:0] cs_word;
  logic [13:0] cs_seed;
  logic [6:0]  cs_fold;
  logic [3:0]  bad_run_inc;

  assign accept  = DI_valid && DI_ready;
  assign lo_byte = DI[7:0];
  assign hi_byte = DI[15:8];

  // Expected values and running checksum derived from the current word
  always_comb begin
    seed_hi_exp = lo_byte[6:0] + CNT_STEP;
    hi_cnt_exp  = exp_cnt + CNT_STEP;
    cs_lo       = cs + {6'd0, lo_byte};
    cs_word     = cs_lo + {6'd0, hi_byte};
    cs_seed     = CS_INIT + {6'd0, lo_byte} + {6'd0, hi_byte};
    cs_fold     = cs_lo[6:0] ^ cs_lo[13:7];
    bad_run_inc = bad_run + 4'd1;
  end

  // Alignment FSM and per-word checking; expected counter always advances from
  // the expected value so one corrupt byte yields one word error
  always_comb begin
    state_nxt   = state;
    wpos_nxt    = wpos;
    exp_cnt_nxt = exp_cnt;
    cs_nxt      = cs;
    bad_run_nxt = bad_run;
    blk_bad_nxt = blk_bad;
    word_err    = 1'b0;
    blk_end     = 1'b0;
    blk_end_bad = 1'b0;
    lose_lock   = 1'b0;
    if (accept) begin
      case (state)
        HUNT: begin
          if (DI[15] && DI[7]) begin
            state_nxt = SEED;
            wpos_nxt  = 3'd0;
          end
        end
        SEED: begin
          word_err    = (hi_byte[7] != 1'b1) || (hi_byte[6:0] != seed_hi_exp);
          exp_cnt_nxt = lo_byte[6:0] + CNT_STEP2;
          cs_nxt      = cs_seed;
          blk_bad_nxt = word_err;
          bad_run_nxt = 4'd0;
          wpos_nxt    = 3'd1;
          state_nxt   = CHECK;
        end
        CHECK: begin
          if (wpos == 3'd7) begin
            word_err    = (lo_byte[7] != 1'b1) || (lo_byte[6:0] != exp_cnt) ||
                          (hi_byte[7] != 1'b1) || (hi_byte[6:0] != cs_fold);
            exp_cnt_nxt = exp_cnt + CNT_STEP;
            cs_nxt      = CS_INIT;
            wpos_nxt    = 3'd0;
            blk_end     = 1'b1;
            blk_end_bad = blk_bad || word_err;
            blk_bad_nxt = 1'b0;
            if (blk_end_bad) begin
              bad_run_nxt = bad_run_inc;
              if (bad_run_inc >= LOSS) begin
                state_nxt = HUNT;
                lose_lock = 1'b1;
              end
            end else begin
              bad_run_nxt = 4'd0;
            end
          end else begin
            word_err    = (lo_byte[7] != 1'b0) || (lo_byte[6:0] != exp_cnt) ||
                          (hi_byte[7] != 1'b1) || (hi_byte[6:0] != hi_cnt_exp);
            exp_cnt_nxt = exp_cnt + CNT_STEP2;
            cs_nxt      = cs_word;
            wpos_nxt    = wpos + 3'd1;
            blk_bad_nxt = blk_bad || word_err;
          end
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Block position, expected counter, checksum and bad-block run tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wpos    <= 3'd0;
      exp_cnt <= 7'd0;
      cs      <= CS_INIT;
      bad_run <= 4'd0;
      blk_bad <= 1'b0;
    end else begin
      wpos    <= wpos_nxt;
      exp_cnt <= exp_cnt_nxt;
      cs      <= cs_nxt;
      bad_run <= bad_run_nxt;
      blk_bad <= blk_bad_nxt;
    end
  end

  // Handshake and status flags; locked covers both the seed word and checking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      DI_ready <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      DI_ready <= 1'b1;
      locked   <= (state_nxt != HUNT);
      err      <= accept && word_err;
    end
  end

  // Error and throughput counters; clear takes priority over any increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt     <= 16'd0;
      blk_ok_cnt  <= 32'd0;
      blk_err_cnt <= 16'd0;
      lock_lost   <= 1'b0;
    end else if (clr) begin
      err_cnt     <= 16'd0;
      blk_ok_cnt  <= 32'd0;
      blk_err_cnt <= 16'd0;
      lock_lost   <= 1'b0;
    end else begin
      if (accept && word_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (blk_end && !blk_end_bad) begin
        blk_ok_cnt <= blk_ok_cnt + 32'd1;
      end
      if (blk_end && blk_end_bad && (blk_err_cnt != 16'hFFFF)) begin
        blk_err_cnt <= blk_err_cnt + 16'd1;
      end
      if (lose_lock) begin
        lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memfifo_test_checker.sv
// tb_memfifo_test_checker: directed bench for memfifo_test_checker driven by a
// generator model; expected err pulses go through a scoreboard queue.
module tb_memfifo_test_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] DI = 16'd0;
  logic        DI_valid = 1'b0;
  logic        DI_ready;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [31:0] blk_ok_cnt;
  logic [15:0] blk_err_cnt;
  logic        lock_lost;

  int n_vec = 0;
  int n_bad = 0;
  bit exp_q[$];

  memfifo_test_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .DI         (DI),
    .DI_valid   (DI_valid),
    .DI_ready   (DI_ready),
    .locked     (locked),
    .err        (err),
    .err_cnt    (err_cnt),
    .blk_ok_cnt (blk_ok_cnt),
    .blk_err_cnt(blk_err_cnt),
    .lock_lost  (lock_lost)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Generator model: counter byte k = 15*blk + i carries (k*111) mod 128,
  // byte 15 carries the folded checksum of bytes 0..14
  function automatic logic [15:0] gen_word(input int blk, input int w);
    logic [7:0]  b [16];
    logic [13:0] cs;
    logic [6:0]  p;
    logic        s;
    cs = 14'd47;
    for (int i = 0; i < 15; i++) begin
      p    = 7'((15 * blk + i) * 111);
      s    = (i % 2 == 1) || (i == 14);
      b[i] = {s, p};
      cs   = cs + {6'd0, b[i]};
    end
    b[15] = {1'b1, cs[6:0] ^ cs[13:7]};
    return {b[2*w+1], b[2*w]};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_output({tag, "_ready"},   {31'd0, DI_ready},  32'd0);
    check_output({tag, "_locked"},  {31'd0, locked},    32'd0);
    check_output({tag, "_err"},     {31'd0, err},       32'd0);
    check_output({tag, "_errcnt"},  {16'd0, err_cnt},   32'd0);
    check_output({tag, "_okcnt"},   blk_ok_cnt,         32'd0);
    check_output({tag, "_blkerr"},  {16'd0, blk_err_cnt}, 32'd0);
    check_output({tag, "_lost"},    {31'd0, lock_lost}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    DI_valid = 1'b0;
    clr      = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals(tag);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output({tag, "_ready_after"}, {31'd0, DI_ready}, 32'd1);
  endtask

  task automatic idle_cycle();
    DI_valid = 1'b0;
    DI       = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    check_output("idle_err", {31'd0, err}, 32'd0);
  endtask

  task automatic apply_word(input logic [15:0] data, input bit exp_err, input bit with_clr);
    DI       = data;
    DI_valid = 1'b1;
    clr      = with_clr;
    exp_q.push_back(exp_err);
    @(posedge clk);
    @(negedge clk);
    DI_valid = 1'b0;
    clr      = 1'b0;
    check_output("word_err", {31'd0, err}, {31'd0, exp_q.pop_front()});
  endtask

  task automatic apply_block(input int blk, input int first_w, input int bad_w,
                             input logic [15:0] xor_mask, input bit exp_bad,
                             input bit gaps, input int clr_w);
    logic [15:0] d;
    for (int w = first_w; w < 8; w++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
      end
      d = gen_word(blk, w);
      if (w == bad_w) d = d ^ xor_mask;
      apply_word(d, (w == bad_w) && exp_bad, w == clr_w);
    end
  endtask

  logic [15:0] cs_word;

  initial begin
    $display("[TB] start");

    // Clean stream: lock on block 0 word 7, blocks 1..4 checked
    do_reset("A_rst");
    apply_block(0, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    check_output("A_lock_early", {31'd0, locked}, 32'd1);
    for (int b = 1; b <= 4; b++) apply_block(b, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    check_output("A_okcnt",  blk_ok_cnt, 32'd4);
    check_output("A_errcnt", {16'd0, err_cnt}, 32'd0);
    check_output("A_blkerr", {16'd0, blk_err_cnt}, 32'd0);
    check_output("A_locked", {31'd0, locked}, 32'd1);
    check_output("A_lost",   {31'd0, lock_lost}, 32'd0);

    // Block 2 word 3: DI[2] flipped; DI[10] flipped too so that the byte sum,
    // and hence the checksum byte, stays correct (-4 on byte 6, +4 on byte 7)
    do_reset("B_rst");
    for (int b = 0; b <= 4; b++) begin
      if (b == 2) apply_block(b, 0, 3, 16'h0404, 1'b1, 1'b0, -1);
      else        apply_block(b, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
      if (b == 2) begin
        check_output("B_errcnt_b2", {16'd0, err_cnt}, 32'd1);
        check_output("B_blkerr_b2", {16'd0, blk_err_cnt}, 32'd1);
      end
    end
    check_output("B_okcnt",  blk_ok_cnt, 32'd3);
    check_output("B_errcnt", {16'd0, err_cnt}, 32'd1);
    check_output("B_blkerr", {16'd0, blk_err_cnt}, 32'd1);

    // Block 1 checksum byte replaced by 0x00
    do_reset("C_rst");
    cs_word = gen_word(1, 7);
    for (int b = 0; b <= 4; b++) begin
      if (b == 1) apply_block(b, 0, 7, {cs_word[15:8], 8'h00}, 1'b1, 1'b0, -1);
      else        apply_block(b, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
      if (b == 1) begin
        check_output("C_blkerr_b1", {16'd0, blk_err_cnt}, 32'd1);
        check_output("C_locked_b1", {31'd0, locked}, 32'd1);
      end
    end
    check_output("C_okcnt",  blk_ok_cnt, 32'd3);
    check_output("C_errcnt", {16'd0, err_cnt}, 32'd1);

    // Four consecutive bad blocks lose lock; clean stream relocks; clr test
    do_reset("D_rst");
    apply_block(0, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    for (int b = 1; b <= 4; b++) begin
      apply_block(b, 0, 7, 16'h0100, 1'b1, 1'b0, -1);
      if (b == 3) check_output("D_locked_b3", {31'd0, locked}, 32'd1);
    end
    check_output("D_locked_lost", {31'd0, locked}, 32'd0);
    check_output("D_lost",        {31'd0, lock_lost}, 32'd1);
    check_output("D_blkerr",      {16'd0, blk_err_cnt}, 32'd4);
    check_output("D_errcnt",      {16'd0, err_cnt}, 32'd4);
    apply_block(5, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    check_output("D_relock", {31'd0, locked}, 32'd1);
    apply_block(6, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    apply_block(7, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    check_output("D_okcnt_relock", blk_ok_cnt, 32'd2);
    check_output("D_lost_sticky",  {31'd0, lock_lost}, 32'd1);
    apply_block(8, 0, -1, 16'h0000, 1'b0, 1'b0, 7);
    check_output("D_clr_okcnt",  blk_ok_cnt, 32'd0);
    check_output("D_clr_errcnt", {16'd0, err_cnt}, 32'd0);
    check_output("D_clr_blkerr", {16'd0, blk_err_cnt}, 32'd0);
    check_output("D_clr_lost",   {31'd0, lock_lost}, 32'd0);
    check_output("D_clr_locked", {31'd0, locked}, 32'd1);
    apply_block(9, 0, -1, 16'h0000, 1'b0, 1'b0, -1);
    check_output("D_post_clr_ok", blk_ok_cnt, 32'd1);

    // Mid-block start with random valid gaps, then reset mid-block
    do_reset("E_rst");
    apply_block(0, 3, -1, 16'h0000, 1'b0, 1'b1, -1);
    check_output("E_lock", {31'd0, locked}, 32'd1);
    for (int b = 1; b <= 3; b++) apply_block(b, 0, -1, 16'h0000, 1'b0, 1'b1, -1);
    check_output("E_okcnt",  blk_ok_cnt, 32'd3);
    check_output("E_errcnt", {16'd0, err_cnt}, 32'd0);
    for (int w = 0; w < 4; w++) apply_word(gen_word(4, w), 1'b0, 1'b0);
    reset_n  = 1'b0;
    DI       = gen_word(4, 4);
    DI_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    DI_valid = 1'b0;
    check_reset_vals("E_midrst");
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
